// File: rtl/ysyx_23060111_mem_arbiter.sv
// rtl/ysyx_23060111_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single memory port
module ysyx_23060111_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    output logic              mem_wen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   own;
    logic   prio;
    logic   grant_lsu;
    logic   handshake;

    // LSU wins when it is the only requester, or both request and it holds priority.
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | prio);

    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        if (!rst && state == IDLE) begin
            ifu_req_ready = ifu_req_valid & ~grant_lsu;
            lsu_req_ready = grant_lsu;
        end
    end

    assign handshake = (ifu_req_valid & ifu_req_ready) | (lsu_req_valid & lsu_req_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (handshake) state_nxt = REQ;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_resp_valid) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req_valid  = (state == REQ);
    assign ifu_resp_valid = (state == RESP) & ~own;
    assign lsu_resp_valid = (state == RESP) & own;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            own       <= 1'b0;
            prio      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_wen   <= 1'b0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && handshake) begin
                own  <= grant_lsu;
                prio <= ~grant_lsu;
                if (grant_lsu) begin
                    mem_addr  <= lsu_addr;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                    mem_wen   <= lsu_wen;
                end else begin
                    mem_addr  <= ifu_addr;
                    mem_wdata <= '0;
                    mem_wmask <= '0;
                    mem_wen   <= 1'b0;
                end
            end
            if (state == WAIT && mem_resp_valid) begin
                if (own) lsu_rdata <= mem_rdata;
                else     ifu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
// tb/tb_ysyx_23060111_mem_arbiter.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_23060111_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    ysyx_23060111_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_wen(mem_wen),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = '0;
        lsu_req_valid = 1'b1; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        step(); step();
        checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", ifu_req_ready, lsu_req_ready); end
        checks++; if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valids got=%b%b%b exp=000", mem_req_valid, ifu_resp_valid, lsu_resp_valid); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wmask !== 8'h0 || mem_wen !== 1'b0) begin failures++; $display("FAIL reset_mem_fields got=%h/%h/%h/%b exp=0", mem_addr, mem_wdata, mem_wmask, mem_wen); end
        checks++; if (ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", ifu_rdata, lsu_rdata); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
        #1;
        checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL ifu_grant got=%b%b exp=10", ifu_req_ready, lsu_req_ready); end
        step();
        ifu_req_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin failures++; $display("FAIL ifu_mem_req got=%b/%h/%b exp=1/80000000/0", mem_req_valid, mem_addr, mem_wen); end
        step();
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL ifu_wait_reqvalid got=%b exp=0", mem_req_valid); end
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        step();
        mem_resp_valid = 1'b0;
        checks++; if (ifu_resp_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || ifu_rdata !== 32'h0000_0413) begin failures++; $display("FAIL ifu_resp got=%b%b/%h exp=10/00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata); end
        step();
        checks++; if (ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL ifu_resp_pulse got=%b exp=0", ifu_resp_valid); end
    endtask

    task automatic test_lsu_write();
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        #1;
        checks++; if (lsu_req_ready !== 1'b1 || ifu_req_ready !== 1'b0) begin failures++; $display("FAIL lsu_grant got=%b%b exp=01", ifu_req_ready, lsu_req_ready); end
        step();
        lsu_req_valid = 1'b0;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 8'h0F || mem_wen !== 1'b1) begin failures++; $display("FAIL lsu_mem_fields got=%h/%h/%h/%b", mem_addr, mem_wdata, mem_wmask, mem_wen); end
        step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_resp_valid = 1'b0;
        checks++; if (lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL lsu_resp got=%b%b exp=01", ifu_resp_valid, lsu_resp_valid); end
        checks++; if (ifu_rdata !== 32'h0000_0413 || lsu_rdata !== 32'h1234_5678) begin failures++; $display("FAIL lsu_rdata got=%h/%h exp=00000413/12345678", ifu_rdata, lsu_rdata); end
        step();
        checks++; if (lsu_resp_valid !== 1'b0) begin failures++; $display("FAIL lsu_resp_pulse got=%b exp=0", lsu_resp_valid); end
        lsu_wen = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_lsu;
        logic [31:0] exp_addr;
        ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b0;
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_lsu = (i % 2) == 1;
            exp_addr = exp_lsu ? 32'h0000_0200 : 32'h0000_0100;
            #1;
            checks++; if (lsu_req_ready !== exp_lsu || ifu_req_ready !== !exp_lsu) begin failures++; $display("FAIL cont_grant%0d got=%b%b exp_lsu=%b", i, ifu_req_ready, lsu_req_ready, exp_lsu); end
            step();
            checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL cont_addr%0d got=%h exp=%h", i, mem_addr, exp_addr); end
            step();
            mem_resp_valid = 1'b1; mem_rdata = 32'hA0 + i;
            step();
            mem_resp_valid = 1'b0;
            checks++; if (lsu_resp_valid !== exp_lsu || ifu_resp_valid !== !exp_lsu) begin failures++; $display("FAIL cont_resp%0d got=%b%b exp_lsu=%b", i, ifu_resp_valid, lsu_resp_valid, exp_lsu); end
            checks++; if ((exp_lsu ? lsu_rdata : ifu_rdata) !== 32'hA0 + i) begin failures++; $display("FAIL cont_rdata%0d got=%h/%h exp=%h", i, ifu_rdata, lsu_rdata, 32'hA0 + i); end
            step();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; mem_req_ready = 1'b0;
        step();
        ifu_addr = 32'hFFFF_FFFF;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0040 || mem_wen !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL bp_req%0d got=%b/%h/%b%b", i, mem_req_valid, mem_addr, ifu_req_ready, lsu_req_ready); end
            mem_req_ready = (i == 3);
            step();
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            checks++; if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL bp_wait%0d got=%b%b%b%b exp=0000", j, mem_req_valid, ifu_resp_valid, ifu_req_ready, lsu_req_ready); end
            step();
        end
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_resp_valid = 1'b0;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'hCAFE_F00D || ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL bp_resp got=%b/%h/%b%b exp=1/cafef00d/00", ifu_resp_valid, ifu_rdata, ifu_req_ready, lsu_req_ready); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_in_wait();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; mem_req_ready = 1'b1;
        step();
        ifu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
        checks++; if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_addr !== 32'h0 || ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin failures++; $display("FAIL rstw_state got=%b%b%b/%h/%h/%h", mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_addr, ifu_rdata, lsu_rdata); end
        step();
        mem_resp_valid = 1'b0;
        checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || ifu_rdata !== 32'h0) begin failures++; $display("FAIL rstw_late_resp got=%b%b%b/%h exp=000/0", ifu_resp_valid, lsu_resp_valid, mem_req_valid, ifu_rdata); end
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #1;
        checks++; if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL rstw_grant got=%b%b exp=10", ifu_req_ready, lsu_req_ready); end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    endtask

    task automatic test_spurious_resp();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0077;
        step();
        checks++; if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL spur_idle got=%b%b%b exp=000", ifu_resp_valid, lsu_resp_valid, mem_req_valid); end
        lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0300; lsu_wen = 1'b0; mem_req_ready = 1'b0;
        step();
        lsu_req_valid = 1'b0;
        step();
        checks++; if (mem_req_valid !== 1'b1 || lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'h0) begin failures++; $display("FAIL spur_req got=%b%b/%h exp=10/0", mem_req_valid, lsu_resp_valid, lsu_rdata); end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        step();
        checks++; if (mem_req_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin failures++; $display("FAIL spur_wait got=%b%b exp=00", mem_req_valid, lsu_resp_valid); end
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0099;
        step();
        mem_resp_valid = 1'b0;
        checks++; if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h0000_0099 || ifu_rdata !== 32'h0) begin failures++; $display("FAIL spur_resp got=%b/%h/%h exp=1/99/0", lsu_resp_valid, lsu_rdata, ifu_rdata); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_write();
        test_contention();
        test_back_pressure();
        test_reset_in_wait();
        test_spurious_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060111_mem_arbiter.md
# ysyx_23060111_mem_arbiter

Two-master arbiter sharing the core's single physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Sits between the IFU/LSU and the memory block. Accepts one request at a time, forwards it on a valid/ready request channel, waits for the memory response and routes it back to the owning master. Round-robin tie-breaking prevents starvation.

## Interface

- ADDR_W, 32, address width
- DATA_W, 32, data width
- MASK_W, 8, write byte-mask width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  arbiter accepts IFU request this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata valid
- ifu_rdata  out  DATA_W  fetched word
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  arbiter accepts LSU request this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  MASK_W  write byte mask
- lsu_resp_valid  out  1  one-cycle pulse: read data / write completion
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wdata, mem_wmask, mem_wen  out  ADDR_W/DATA_W/MASK_W/1  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, REQ, WAIT, RESP. Owner register own (0 = IFU, 1 = LSU); tie-break register prio (0 = IFU preferred, 1 = LSU preferred).
- IDLE: grant computed combinationally. Only one valid: that master wins. Both valid: master selected by prio wins. The winner's req_ready = 1, the loser's = 0. Outside IDLE, both req_ready = 0.
- Handshake (valid & ready in IDLE): latch addr/wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0); set own to the winner; set prio to the other master; go to REQ.
- REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready go to WAIT. mem_resp_valid is ignored in REQ.
- WAIT: mem_req_valid=0. On mem_resp_valid, latch mem_rdata into the owner's rdata register and go to RESP.
- RESP: owner's resp_valid=1 for exactly one cycle; next state IDLE.
- Writes also complete through mem_resp_valid. lsu_resp_valid pulses; lsu_rdata takes mem_rdata and is don't-care for writes.
- ifu_rdata/lsu_rdata hold their last value until that master's next response. The non-owner's rdata never changes.
- Masters hold req fields stable only until handshake; the arbiter does not re-sample them afterwards.
- Only one transaction is outstanding at a time; no pipelining.

## Timing

- Reset (rst=1 at an edge): state=IDLE, prio=0, own=0, mem_req_valid=0, both resp_valid=0, both rdata=0, mem_addr/wdata/wmask/wen=0. While rst is high, both req_ready are forced to 0.
- Reset mid-transaction: the transaction is abandoned with no resp_valid. A late mem_resp_valid after reset is ignored because the FSM is in IDLE.
- Minimum turnaround (mem_req_ready=1 in the first REQ cycle, mem_resp_valid in the first WAIT cycle):
  - handshake at cycle 0
  - mem_req_valid in cycle 1
  - WAIT in cycle 2
  - resp_valid in cycle 3
  - next handshake possible in cycle 4
- Back-pressure: each low cycle of mem_req_ready extends REQ by one cycle, with fields held stable. Each cycle without mem_resp_valid extends WAIT by one cycle.
- Contention: under a continuous dual request, grants alternate IFU, LSU, IFU, … starting with IFU after reset.
- A request arriving during REQ/WAIT/RESP waits (ready=0) and is considered in the next IDLE cycle.

## Test plan

- **Single IFU read.** After reset, ifu_req_valid=1, ifu_addr=0x80000000; memory has ready=1 and returns 0x00000413 one cycle later. Required: mem_addr=0x80000000, mem_wen=0; ifu_resp_valid pulses at cycle 3 with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
- **LSU write.** lsu_wen=1, lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF, lsu_wmask=0x0F. Required: mem fields match exactly and mem_wen=1; lsu_resp_valid pulses once; ifu_rdata is unchanged.
- **Simultaneous requests held for 4 transactions.** Required: grant order IFU, LSU, IFU, LSU; each resp_valid goes only to the owner.
- **Back-pressure.** mem_req_ready held low for 3 cycles, then mem_resp_valid delayed 5 cycles. Required: mem_req_valid is high for 4 cycles with constant fields; resp_valid fires 1 cycle after mem_resp_valid; both req_ready are 0 throughout.
- **Reset during WAIT.** Assert rst for 1 cycle, then drive mem_resp_valid. Required: no resp_valid pulse, all outputs at reset values, and the next IFU request is granted first.
- **Spurious response.** mem_resp_valid=1 while in IDLE or REQ. Required: ignored, no resp_valid, state unchanged.
